adder4_nibble_sched: RTL and testbench
======================================

# adder4_nibble_sched

Two-requester scheduler that shares one 4-bit carry-lookahead nibble adder to perform 16-bit add/subtract operations nibble-serially. It arbitrates round-robin between two requesters and latches the winner's operands. It then steps the nibble adder LSB-first over N_NIB cycles with a registered carry and returns the result with a one-cycle done pulse. It sits between the host-facing operand registers and the shared nibble datapath.

## Interface
- N_NIB, 4: nibbles per operand; operand width W = 4*N_NIB.
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- req  in  2  request per requester (bit i = requester i); level, held until done for that requester.
- op  in  2  op per requester: 0 = add (a+b), 1 = subtract (a−b).
- a0, b0  in  W  operands, requester 0.
- a1, b1  in  W  operands, requester 1.
- gnt  out  2  one-hot grant; high from grant until done cycle inclusive.
- busy  out  1  high in ADD and DONE states.
- done  out  1  one-cycle pulse; sum/cout valid.
- done_id  out  1  requester served by the current/last done.
- sum  out  W  result.
- cout  out  1  final carry (add: overflow out; subtract: 1 = no borrow).

## Operation
- States: IDLE, ADD, DONE.
- IDLE: if any req bit high, pick winner, latch a/b/op of winner, set gnt, idx=0, carry=op (carry-in 1 for subtract), go ADD. Else stay.
- Arbitration: single request wins directly. Both high: grant requester != last_id; last_id resets to 1 so requester 0 wins first tie.
- ADD: nibble k=idx; s = A[k] + (op ? ~B[k] : B[k]) + carry (5-bit); write s[3:0] to sum nibble k, carry <= s[4], idx <= idx+1. On idx = N_NIB−1, cout <= s[4], go DONE.
- DONE: done=1, done_id=winner, gnt still high; last_id <= winner; go IDLE (gnt cleared).
- req input is ignored while busy; dropping req mid-operation does not abort. Operand changes after the grant edge have no effect.
- Requester still holding req after its done is re-arbitrated normally (round-robin prevents starvation).
- sum/cout contents are defined only in the done cycle; they hold their value until the next grant edge, then sum is overwritten nibble-by-nibble.
- Arithmetic modulo 2^W; no saturation; no signed overflow flag.

## Timing
- Reset (rst_n low at an edge): state IDLE, gnt=00, busy=0, done=0, done_id=0, sum=0, cout=0, idx=0, carry=0, last_id=1. Reset takes priority in any state; an operation in progress is abandoned with no done.
- Edge E0: req sampled in IDLE -> gnt/busy high after E0.
- Edges E1..E(N_NIB): one nibble each; after E(N_NIB) state DONE, done high for exactly one cycle.
- Edge E(N_NIB+1): IDLE, gnt=00, busy=0. Earliest next grant at E(N_NIB+2).
- Latency req-sampled to done = N_NIB edges after grant (4 cycles for default). Throughput: one op per N_NIB+2 cycles.
- Carry is registered between nibbles; combinational path is one nibble adder only.

## Test plan
- Reset: hold rst_n low 2 cycles with req=11 -> gnt=00, busy=0, done=0, sum=0x0000, cout=0; after release, first grant is gnt=01.
- Single add: req=01, a0=0x1234, b0=0x4321, op=00 -> gnt=01 next cycle, done 4 cycles after grant, sum=0x5555, cout=0, done_id=0.
- Full carry ripple: req=10, a1=0xFFFF, b1=0x0001, op=00 -> sum=0x0000, cout=1, done_id=1.
- Subtract: req=01, op=01, a0=0x0005, b0=0x0007 -> sum=0xFFFE, cout=0; then a0=0x0007, b0=0x0005 -> sum=0x0002, cout=1.
- Contention: req=11 held constantly with distinct operands -> done_id sequence 0,1,0,1; dones spaced 6 cycles apart; gnt never 11; operand change mid-op does not alter result.
- Reset mid-op: rst_n low on the edge after the second nibble -> no done pulse, all outputs at reset values next cycle, new req afterwards completes correctly.

Source files
------------

// File: rtl/adder4_nibble_sched.sv
// adder4_nibble_sched
//
// Shares one 4-bit carry-lookahead nibble adder between two requesters to
// perform W-bit add/subtract operations nibble-serially (LSB nibble first).
// A round-robin arbiter picks a winner in IDLE and latches its operands. The
// nibble adder is then stepped over N_NIB cycles with a registered carry, and
// the result is returned with a one-cycle done pulse.
//
// Ports:
//   clk      in   clock, all state changes on the rising edge
//   rst_n    in   synchronous active-low reset
//   req      in   [1:0] level request per requester, held until its done
//   op       in   [1:0] per-requester op: 0 = a+b, 1 = a-b
//   a0, b0   in   [W-1:0] operands of requester 0
//   a1, b1   in   [W-1:0] operands of requester 1
//   gnt      out  [1:0] one-hot grant, high from grant through done cycle
//   busy     out  high in ADD and DONE states
//   done     out  one-cycle pulse, sum/cout valid
//   done_id  out  requester served by the current/last done
//   sum      out  [W-1:0] result
//   cout     out  final carry (add: carry out, subtract: 1 = no borrow)
module adder4_nibble_sched #(
    parameter int N_NIB = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           req,
    input  logic [1:0]           op,
    input  logic [4*N_NIB-1:0]   a0,
    input  logic [4*N_NIB-1:0]   b0,
    input  logic [4*N_NIB-1:0]   a1,
    input  logic [4*N_NIB-1:0]   b1,
    output logic [1:0]           gnt,
    output logic                 busy,
    output logic                 done,
    output logic                 done_id,
    output logic [4*N_NIB-1:0]   sum,
    output logic                 cout
);

    localparam int W     = 4 * N_NIB;
    localparam int IDX_W = (N_NIB > 1) ? $clog2(N_NIB) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NIB - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADD  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // 4-bit carry-lookahead adder: returns {carry_out, sum[3:0]}.
    function automatic logic [4:0] cla4(input logic [3:0] x,
                                        input logic [3:0] y,
                                        input logic       cin);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g = x & y;
        p = x ^ y;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        return {c[4], p ^ c[3:0]};
    endfunction

    // Control state (reset)
    logic [1:0]       state_q,   state_d;
    logic [1:0]       gnt_q,     gnt_d;
    logic [IDX_W-1:0] idx_q,     idx_d;
    logic             carry_q,   carry_d;
    logic             last_id_q, last_id_d;
    logic             done_id_q, done_id_d;
    logic [W-1:0]     sum_q,     sum_d;
    logic             cout_q,    cout_d;

    // Latched operands of the current winner (no reset needed: always
    // written on the grant edge before being used)
    logic [W-1:0]     a_q,       a_d;
    logic [W-1:0]     b_q,       b_d;
    logic             op_q,      op_d;
    logic             winner_q,  winner_d;

    logic             win;
    logic [3:0]       nib_a;
    logic [3:0]       nib_b;
    logic [4:0]       nib_s;

    // Round-robin: on a tie the requester that was not served last wins.
    always_comb begin
        win = 1'b0;
        case (req)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            2'b11:   win = ~last_id_q;
            default: win = 1'b0;
        endcase
    end

    // Nibble select for the current index; subtract uses a + ~b + 1 with
    // the +1 supplied as the initial carry.
    always_comb begin
        nib_a = 4'd0;
        nib_b = 4'd0;
        for (int k = 0; k < N_NIB; k++) begin
            if (idx_q == IDX_W'(k)) begin
                nib_a = a_q[4*k +: 4];
                nib_b = b_q[4*k +: 4];
            end
        end
        nib_s = cla4(nib_a, op_q ? ~nib_b : nib_b, carry_q);
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        last_id_d = last_id_q;
        done_id_d = done_id_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        winner_d  = winner_q;

        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    winner_d = win;
                    gnt_d    = win ? 2'b10 : 2'b01;
                    a_d      = win ? a1 : a0;
                    b_d      = win ? b1 : b0;
                    op_d     = op[win];
                    carry_d  = op[win];
                    idx_d    = '0;
                    state_d  = ST_ADD;
                end
            end
            ST_ADD: begin
                for (int k = 0; k < N_NIB; k++) begin
                    if (idx_q == IDX_W'(k)) begin
                        sum_d[4*k +: 4] = nib_s[3:0];
                    end
                end
                carry_d = nib_s[4];
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    cout_d    = nib_s[4];
                    done_id_d = winner_q;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                last_id_d = winner_q;
                gnt_d     = 2'b00;
                state_d   = ST_IDLE;
            end
            default: begin
                gnt_d   = 2'b00;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            gnt_q     <= 2'b00;
            idx_q     <= '0;
            carry_q   <= 1'b0;
            last_id_q <= 1'b1;
            done_id_q <= 1'b0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            idx_q     <= idx_d;
            carry_q   <= carry_d;
            last_id_q <= last_id_d;
            done_id_q <= done_id_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
        end
    end

    always_ff @(posedge clk) begin
        a_q      <= a_d;
        b_q      <= b_d;
        op_q     <= op_d;
        winner_q <= winner_d;
    end

    assign gnt     = gnt_q;
    assign busy    = (state_q == ST_ADD) || (state_q == ST_DONE);
    assign done    = (state_q == ST_DONE);
    assign done_id = done_id_q;
    assign sum     = sum_q;
    assign cout    = cout_q;

endmodule

// File: tb/tb_adder4_nibble_sched.sv
module tb_adder4_nibble_sched;

    localparam int N_NIB = 4;
    localparam int W     = 4 * N_NIB;

    logic         clk;
    logic         rst_n;
    logic [1:0]   req;
    logic [1:0]   op;
    logic [W-1:0] a0, b0, a1, b1;
    logic [1:0]   gnt;
    logic         busy;
    logic         done;
    logic         done_id;
    logic [W-1:0] sum;
    logic         cout;

    adder4_nibble_sched #(.N_NIB(N_NIB)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .op      (op),
        .a0      (a0),
        .b0      (b0),
        .a1      (a1),
        .b1      (b1),
        .gnt     (gnt),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .sum     (sum),
        .cout    (cout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic         id;
        logic [W-1:0] sum;
        logic         cout;
    } exp_t;

    exp_t sb[$];

    int n_cmp       = 0;
    int n_bad       = 0;
    int n_done      = 0;
    int cyc         = 0;
    int last_done   = -1;
    bit spacing_en  = 1'b0;
    bit gnt_both    = 1'b0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference arithmetic, computed at full width.
    function automatic exp_t model(input logic id, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic o);
        exp_t e;
        logic [W:0] r;
        if (o) r = {1'b0, a} + {1'b0, ~b} + 1;
        else   r = {1'b0, a} + {1'b0, b};
        e.id   = id;
        e.sum  = r[W-1:0];
        e.cout = r[W];
        return e;
    endfunction

    // Output monitor: pops the scoreboard on every done pulse.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (gnt == 2'b11) gnt_both = 1'b1;
        if (rst_n && done) begin
            n_done++;
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("sum", sum, e.sum);
                check("cout", cout, e.cout);
                check("done_id", done_id, e.id);
                check("gnt_at_done", gnt, e.id ? 32'd2 : 32'd1);
                if (spacing_en && last_done >= 0)
                    check("done_spacing", cyc - last_done, 32'd6);
                last_done = cyc;
            end
        end
    end

    task automatic wait_dones(input int target, input int budget);
        while (n_done < target && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (n_done < target) check("timeout_dones", n_done, target);
        #1;
    endtask

    // Entered at a negedge in IDLE; runs one isolated operation.
    task automatic run_op(input logic id, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic o);
        if (id) begin a1 = a; b1 = b; end
        else    begin a0 = a; b0 = b; end
        op[id] = o;
        req    = id ? 2'b10 : 2'b01;
        sb.push_back(model(id, a, b, o));
        @(negedge clk);
        check("gnt_after_req", gnt, id ? 32'd2 : 32'd1);
        check("busy_after_req", busy, 32'd1);
        repeat (3) @(negedge clk);
        check("no_early_done", done, 32'd0);
        @(negedge clk);
        check("done_latency", done, 32'd1);
        req = 2'b00;
        @(negedge clk);
        check("gnt_cleared", gnt, 32'd0);
        check("busy_cleared", busy, 32'd0);
        check("done_one_cycle", done, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 2'b11;
        op    = 2'b10;
        a0 = 16'h1111; b0 = 16'h0F0F;
        a1 = 16'h8000; b1 = 16'h0001;

        // Reset held two edges with both requests up.
        repeat (2) @(negedge clk);
        check("rst_gnt", gnt, 32'd0);
        check("rst_busy", busy, 32'd0);
        check("rst_done", done, 32'd0);
        check("rst_sum", sum, 32'd0);
        check("rst_cout", cout, 32'd0);
        check("rst_done_id", done_id, 32'd0);

        // Contention: req=11 held, alternating service, a0 changed mid-op.
        sb.push_back(model(1'b0, 16'h1111, 16'h0F0F, 1'b0));
        sb.push_back(model(1'b1, 16'h8000, 16'h0001, 1'b1));
        sb.push_back(model(1'b0, 16'h2222, 16'h0F0F, 1'b0));
        sb.push_back(model(1'b1, 16'h8000, 16'h0001, 1'b1));
        spacing_en = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        check("first_grant", gnt, 32'd1);
        @(negedge clk);
        a0 = 16'h2222;
        wait_dones(4, 100);
        req = 2'b00;
        @(negedge clk);
        spacing_en = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_after_contention", busy, 32'd0);

        // Isolated operations.
        run_op(1'b0, 16'h1234, 16'h4321, 1'b0);
        run_op(1'b1, 16'hFFFF, 16'h0001, 1'b0);
        run_op(1'b0, 16'h0005, 16'h0007, 1'b1);
        run_op(1'b0, 16'h0007, 16'h0005, 1'b1);
        run_op(1'b1, 16'h0F0F, 16'h00F1, 1'b0);

        // Reset on the edge after the second nibble; no done may follow.
        a1 = 16'hABCD; b1 = 16'h1234; op = 2'b00;
        req = 2'b10;
        @(negedge clk);
        check("abort_gnt", gnt, 32'd2);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        req   = 2'b00;
        @(negedge clk);
        check("abort_gnt_rst", gnt, 32'd0);
        check("abort_busy_rst", busy, 32'd0);
        check("abort_done_rst", done, 32'd0);
        check("abort_sum_rst", sum, 32'd0);
        check("abort_cout_rst", cout, 32'd0);
        check("abort_done_id_rst", done_id, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        run_op(1'b1, 16'h7FFF, 16'h8001, 1'b0);

        repeat (2) @(negedge clk);
        check("scoreboard_empty", sb.size(), 32'd0);
        check("gnt_never_both", gnt_both, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
